// File: rtl/exe_unit_seq_pkg.sv
// Shared definitions for the sequential execution unit: opcode encodings,
// FSM state type and the result-flag helper.
package exe_pkg;

  // Widest result the flag helper can inspect; BITS must not exceed this.
  localparam int FLAG_MAX_BITS = 64;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_NOR  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_GRAY = 4'b0101;
  localparam logic [3:0] OP_ZCNT = 4'b0110;
  localparam logic [3:0] OP_OH2B = 4'b0111;
  localparam logic [3:0] OP_CRC  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Returns {OF, BF, PF} for the low 'bits' bits of result:
  // all ones, exactly one bit set, odd number of set bits.
  function automatic logic [2:0] flags(input logic [FLAG_MAX_BITS-1:0] result,
                                       input int bits);
    int  ones;
    logic all_ones;
    ones     = 0;
    all_ones = 1'b1;
    for (int i = 0; i < FLAG_MAX_BITS; i++) begin
      if (i < bits) begin
        if (result[i]) ones++;
        else all_ones = 1'b0;
      end
    end
    return {all_ones, (ones == 1), ones[0]};
  endfunction

endpackage

// File: rtl/exe_unit_seq_if.sv
// Operand/result handshake bundle for exe_unit_seq. The slave modport is the
// execution unit, the master modport is whoever issues work and drains results.
interface exe_unit_seq_if #(
  parameter int BITS = 8,
  parameter int N    = 4
);
  logic            i_valid;
  logic            o_ready;
  logic [N-1:0]    i_oper;
  logic [BITS-1:0] i_argA;
  logic [BITS-1:0] i_argB;
  logic            o_valid;
  logic            i_ready;
  logic [BITS-1:0] o_result;
  logic            o_OF;
  logic            o_BF;
  logic            o_PF;
  logic            o_VF;

  modport slave (
    input  i_valid, i_oper, i_argA, i_argB, i_ready,
    output o_ready, o_valid, o_result, o_OF, o_BF, o_PF, o_VF
  );

  modport master (
    output i_valid, i_oper, i_argA, i_argB, i_ready,
    input  o_ready, o_valid, o_result, o_OF, o_BF, o_PF, o_VF
  );
endinterface

// File: rtl/exe_unit_seq_serial_core.sv
// Bit-serial datapath for exe_unit_seq: CRC over operand A (MSB first) and,
// when EXE_SEQ_MUL_EN is defined, an unsigned shift-add multiplier.
// A start pulse performs the first iteration immediately from the live
// operands; done pulses one cycle after the last of BITS iterations.
module exe_serial_core #(
  parameter int BITS  = 8,
  parameter int CRC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef EXE_SEQ_MUL_EN
  input  logic             mul_sel,
  input  logic [BITS-1:0]  arg_b,
`endif
  input  logic [BITS-1:0]  arg_a,
  input  logic [CRC_W-1:0] poly,
  output logic             done,
  output logic [BITS-1:0]  result,
  output logic             ovf
);

  localparam int LEN = $clog2(BITS);

  logic             busy;
  logic [LEN-1:0]   cnt;
  logic [BITS-1:0]  data;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-1:0] poly_q;

  logic [BITS-1:0]  data_cur;
  logic [CRC_W-1:0] crc_cur;
  logic [CRC_W-1:0] poly_cur;
  logic [CRC_W-1:0] crc_nxt;
  logic             fb;

  // One CRC step, sourcing fresh operands on start so no cycle is lost loading.
  always_comb begin
    crc_cur  = start ? '0 : crc;
    data_cur = start ? arg_a : data;
    poly_cur = start ? poly : poly_q;
    fb       = crc_cur[CRC_W-1] ^ data_cur[BITS-1];
    crc_nxt  = (crc_cur << 1) ^ (fb ? poly_cur : '0);
  end

  // Iteration counter and CRC/shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      data   <= '0;
      crc    <= '0;
      poly_q <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= LEN'(1);
      end else if (busy) begin
        cnt <= cnt + LEN'(1);
        if (cnt == LEN'(BITS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
      if (start || busy) begin
        crc    <= crc_nxt;
        data   <= data_cur << 1;
        poly_q <= poly_cur;
      end
    end
  end

`ifdef EXE_SEQ_MUL_EN
  logic [BITS-1:0] hi;
  logic [BITS-1:0] lo;
  logic [BITS-1:0] mcand;
  logic [BITS-1:0] hi_cur;
  logic [BITS-1:0] lo_cur;
  logic [BITS-1:0] mcand_cur;
  logic [BITS:0]   sum;
  logic            mul_q;

  // One shift-add step: add multiplicand when the multiplier LSB is set.
  always_comb begin
    hi_cur    = start ? '0 : hi;
    lo_cur    = start ? arg_b : lo;
    mcand_cur = start ? arg_a : mcand;
    sum       = {1'b0, hi_cur} + (lo_cur[0] ? {1'b0, mcand_cur} : '0);
  end

  // Product register {hi, lo} shifts right one place per iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      mul_q <= 1'b0;
    end else begin
      if (start) mul_q <= mul_sel;
      if (start || busy) begin
        hi    <= sum[BITS:1];
        lo    <= {sum[0], lo_cur[BITS-1:1]};
        mcand <= mcand_cur;
      end
    end
  end

  assign result = mul_q ? lo : {{(BITS-CRC_W){1'b0}}, crc};
  assign ovf    = mul_q & (|hi);
`else
  assign result = {{(BITS-CRC_W){1'b0}}, crc};
  assign ovf    = 1'b0;
`endif

endmodule

// File: rtl/exe_unit_seq.sv
// Handshaked sequential execution unit. Single-cycle ops answer one clock
// after acceptance; CRC (and multiply when EXE_SEQ_MUL_EN is defined) run
// bit-serially in exe_serial_core. Results and flags are held in HOLD until
// the consumer takes them.
module exe_unit_seq
  import exe_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int N     = 4,
  parameter int CRC_W = 4
) (
  input logic          i_clk,
  input logic          i_rst_n,
  exe_unit_seq_if.slave bus
);

  localparam int LEN = $clog2(BITS);

  state_t          state;
  logic            accept;
  logic            is_serial;
  logic [BITS-1:0] result_q;
  logic            of_q, bf_q, pf_q, vf_q;

  logic [BITS-1:0] sc_result;
  logic            sc_vf;
  logic [2:0]      sc_flags;
  logic [BITS-1:0] sum_ab;
  logic [BITS-1:0] diff_ab;
  logic [BITS-1:0] zeros;
  logic [BITS-1:0] oh_idx;
  int              ones;
  logic            big_b;
  logic [LEN-1:0]  sh;

  logic            core_done;
  logic [BITS-1:0] core_result;
  logic            core_ovf;
  logic [2:0]      core_flags;

  assign bus.o_ready  = (state == IDLE);
  assign bus.o_valid  = (state == HOLD);
  assign bus.o_result = result_q;
  assign bus.o_OF     = of_q;
  assign bus.o_BF     = bf_q;
  assign bus.o_PF     = pf_q;
  assign bus.o_VF     = vf_q;

  assign accept = bus.i_valid && bus.o_ready;

`ifdef EXE_SEQ_MUL_EN
  assign is_serial = (bus.i_oper == N'(OP_CRC)) || (bus.i_oper == N'(OP_MUL));
`else
  assign is_serial = (bus.i_oper == N'(OP_CRC));
`endif

  // Single-cycle result from the live operands; only captured on accept.
  always_comb begin
    sc_result = '1;
    sc_vf     = 1'b0;
    sum_ab    = bus.i_argA + bus.i_argB;
    diff_ab   = bus.i_argA - bus.i_argB;
    zeros     = '0;
    oh_idx    = '0;
    ones      = 0;
    big_b     = ({1'b0, bus.i_argB} >= (BITS+1)'(BITS));
    sh        = bus.i_argB[LEN-1:0];
    for (int i = 0; i < BITS; i++) begin
      if (bus.i_argA[i]) begin
        ones++;
        oh_idx = BITS'(i);
      end else begin
        zeros = zeros + BITS'(1);
      end
    end
    case (bus.i_oper)
      N'(OP_ADD): begin
        sc_result = sum_ab;
        sc_vf = (bus.i_argA[BITS-1] == bus.i_argB[BITS-1]) &&
                (sum_ab[BITS-1] != bus.i_argA[BITS-1]);
      end
      N'(OP_NOR):  sc_result = ~(bus.i_argA | bus.i_argB);
      N'(OP_NAND): sc_result = ~(bus.i_argA & bus.i_argB);
      N'(OP_SHL):  sc_result = big_b ? '0 : (bus.i_argA << sh);
      N'(OP_SRA):  sc_result = big_b ? {BITS{bus.i_argA[BITS-1]}}
                                     : BITS'($signed(bus.i_argA) >>> sh);
      N'(OP_GRAY): sc_result = bus.i_argA ^ (bus.i_argA >> 1);
      N'(OP_ZCNT): sc_result = zeros;
      N'(OP_OH2B): sc_result = (ones == 1) ? oh_idx : '1;
      N'(OP_SUB): begin
        sc_result = diff_ab;
        sc_vf = (bus.i_argA[BITS-1] != bus.i_argB[BITS-1]) &&
                (diff_ab[BITS-1] != bus.i_argA[BITS-1]);
      end
      default: sc_result = '1;
    endcase
  end

  assign sc_flags   = flags(FLAG_MAX_BITS'(sc_result), BITS);
  assign core_flags = flags(FLAG_MAX_BITS'(core_result), BITS);

  exe_serial_core #(
    .BITS (BITS),
    .CRC_W(CRC_W)
  ) u_core (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (accept && is_serial),
`ifdef EXE_SEQ_MUL_EN
    .mul_sel(bus.i_oper == N'(OP_MUL)),
    .arg_b  (bus.i_argB),
`endif
    .arg_a  (bus.i_argA),
    .poly   (bus.i_argB[CRC_W-1:0]),
    .done   (core_done),
    .result (core_result),
    .ovf    (core_ovf)
  );

  // IDLE/CALC/HOLD sequencing with result and flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      result_q <= '0;
      of_q     <= 1'b0;
      bf_q     <= 1'b0;
      pf_q     <= 1'b0;
      vf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_serial) begin
              state <= CALC;
            end else begin
              state                <= HOLD;
              result_q             <= sc_result;
              {of_q, bf_q, pf_q}   <= sc_flags;
              vf_q                 <= sc_vf;
            end
          end
        end
        CALC: begin
          if (core_done) begin
            state                <= HOLD;
            result_q             <= core_result;
            {of_q, bf_q, pf_q}   <= core_flags;
            vf_q                 <= core_ovf;
          end
        end
        HOLD: begin
          if (bus.i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_unit_seq.sv
// Scoreboard bench for exe_unit_seq (BITS=8, CRC_W=4). Expected results are
// queued when a vector is issued and checked by an independent monitor
// whenever o_valid is high. EXE_SEQ_MUL_EN selects the multiply expectation.
module tb_exe_unit_seq;
  import exe_pkg::*;

  localparam int BITS  = 8;
  localparam int N     = 4;
  localparam int CRC_W = 4;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   acc_cycle = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   seen_first = 1'b0;
  exp_t sb[$];

  exe_unit_seq_if #(.BITS(BITS), .N(N)) bus ();

  exe_unit_seq #(.BITS(BITS), .N(N), .CRC_W(CRC_W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: compare every valid cycle against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t cur;
    if (rst_n && bus.o_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'(sb.size()), 32'd1);
      end else begin
        cur = sb[0];
        checkOutput({cur.name, "_result"}, 32'(bus.o_result), 32'(cur.res));
        checkOutput({cur.name, "_flags"},
                    32'({bus.o_OF, bus.o_BF, bus.o_PF, bus.o_VF}), 32'(cur.flg));
        if (!seen_first) begin
          checkOutput({cur.name, "_latency"}, 32'(cyc - acc_cycle), 32'(cur.lat));
          seen_first = 1'b1;
        end
        if (bus.i_ready) begin
          void'(sb.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  // Queue the expectation, present the vector and hold it until accepted.
  task automatic applyStimulus(input string name, input logic [3:0] op,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] res, input logic [3:0] flg,
                               input int lat);
    exp_t e;
    int   k;
    e.name = name;
    e.res  = res;
    e.flg  = flg;
    e.lat  = lat;
    sb.push_back(e);
    bus.i_oper  = op;
    bus.i_argA  = a;
    bus.i_argB  = b;
    bus.i_valid = 1'b1;
    k = 0;
    while (!bus.o_ready && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput({name, "_ready_wait"}, 32'(k < 64), 32'd1);
    acc_cycle = cyc;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_oper  = 4'hF;
    bus.i_argA  = ~a;
    bus.i_argB  = ~b;
  endtask

  task automatic waitIdle(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput({name, "_drain"}, 32'(sb.size()), 32'd0);
    if (sb.size() != 0) begin
      sb.delete();
      seen_first = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic runOp(input string name, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic [3:0] flg,
                       input int lat);
    applyStimulus(name, op, a, b, res, flg, lat);
    waitIdle(name);
  endtask

  // Hard stop in case something above never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit ready_low;
    bit hold_ok;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_oper  = '0;
    bus.i_argA  = '0;
    bus.i_argB  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid",  32'(bus.o_valid), 32'd0);
    checkOutput("reset_result", 32'(bus.o_result), 32'd0);
    checkOutput("reset_flags",  32'({bus.o_OF, bus.o_BF, bus.o_PF, bus.o_VF}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_ready", 32'(bus.o_ready), 32'd1);

    // Flags column is {OF, BF, PF, VF}.
    runOp("add_ovf",   OP_ADD,  8'd100, 8'd50, 8'h96, 4'b0001, 1);
    runOp("oh_10",     OP_OH2B, 8'h10,  8'h00, 8'h04, 4'b0110, 1);
    runOp("oh_11",     OP_OH2B, 8'h11,  8'h00, 8'hFF, 4'b1000, 1);
    runOp("oh_00",     OP_OH2B, 8'h00,  8'h00, 8'hFF, 4'b1000, 1);
    runOp("nor",       OP_NOR,  8'h0F,  8'h30, 8'hC0, 4'b0000, 1);
    runOp("nand",      OP_NAND, 8'hF0,  8'h3C, 8'hCF, 4'b0000, 1);
    runOp("shl_2",     OP_SHL,  8'h03,  8'h02, 8'h0C, 4'b0000, 1);
    runOp("shl_7",     OP_SHL,  8'h81,  8'h07, 8'h80, 4'b0110, 1);
    runOp("shl_8",     OP_SHL,  8'h01,  8'h08, 8'h00, 4'b0000, 1);
    runOp("sra_3",     OP_SRA,  8'h80,  8'h03, 8'hF0, 4'b0000, 1);
    runOp("sra_9",     OP_SRA,  8'h80,  8'h09, 8'hFF, 4'b1000, 1);
    runOp("gray",      OP_GRAY, 8'h0B,  8'h00, 8'h0E, 4'b0010, 1);
    runOp("zcnt_01",   OP_ZCNT, 8'h01,  8'h00, 8'h07, 4'b0010, 1);
    runOp("zcnt_ff",   OP_ZCNT, 8'hFF,  8'h00, 8'h00, 4'b0000, 1);
    runOp("sub_ovf",   OP_SUB,  8'h80,  8'h01, 8'h7F, 4'b0011, 1);
    runOp("sub",       OP_SUB,  8'h05,  8'h03, 8'h02, 4'b0110, 1);
    runOp("add_7f",    OP_ADD,  8'h7F,  8'h01, 8'h80, 4'b0111, 1);
    runOp("bad_op_f",  4'hF,    8'h12,  8'h34, 8'hFF, 4'b1000, 1);
    runOp("bad_op_b",  4'hB,    8'h12,  8'h34, 8'hFF, 4'b1000, 1);

    // CRC with i_valid pulses while busy; they must not be accepted.
    applyStimulus("crc", OP_CRC, 8'h80, 8'h03, 8'h0E, 4'b0010, 9);
    ready_low = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 1) begin
        bus.i_valid = 1'b1;
        bus.i_oper  = OP_ADD;
        bus.i_argA  = 8'h01;
        bus.i_argB  = 8'h01;
      end
      if (k == 3) bus.i_valid = 1'b0;
      @(negedge clk);
      if (bus.o_ready) ready_low = 1'b0;
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    checkOutput("crc_ready_low", 32'(ready_low), 32'd1);
    waitIdle("crc");

    // Backpressure: result held while i_ready is low.
    bus.i_ready = 1'b0;
    applyStimulus("bp_add", OP_ADD, 8'h01, 8'h01, 8'h02, 4'b0110, 1);
    hold_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.o_ready || !bus.o_valid) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("bp_hold", 32'(hold_ok), 32'd1);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_idle_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("bp_idle_valid", 32'(bus.o_valid), 32'd0);
    waitIdle("bp");

    // Reset part-way through a CRC discards everything held.
    applyStimulus("rst_crc", OP_CRC, 8'hFF, 8'h03, 8'h00, 4'b0000, 9);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_calc_valid",  32'(bus.o_valid), 32'd0);
    checkOutput("rst_calc_result", 32'(bus.o_result), 32'd0);
    checkOutput("rst_calc_flags",  32'({bus.o_OF, bus.o_BF, bus.o_PF, bus.o_VF}), 32'd0);
    sb.delete();
    seen_first = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runOp("after_rst_add", OP_ADD, 8'd100, 8'd50, 8'h96, 4'b0001, 1);

    // Reset while a result is being held.
    bus.i_ready = 1'b0;
    applyStimulus("rst_hold", OP_ADD, 8'h05, 8'h03, 8'h08, 4'b0110, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_hold_valid",  32'(bus.o_valid), 32'd0);
    checkOutput("rst_hold_result", 32'(bus.o_result), 32'd0);
    sb.delete();
    seen_first = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runOp("after_rst_crc", OP_CRC, 8'h80, 8'h03, 8'h0E, 4'b0010, 9);

`ifdef EXE_SEQ_MUL_EN
    runOp("mul", OP_MUL, 8'd20, 8'd13, 8'h04, 4'b0111, 9);
`else
    runOp("mul_off", OP_MUL, 8'd20, 8'd13, 8'hFF, 4'b1000, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exe_unit_seq.md
Name: exe_unit_seq

Overview:
Parametrised, handshaked successor to the team's combinational ALU execution unit. Operands and opcode are latched on an input valid/ready handshake. Single-cycle ops complete in 1 clock; serial CRC (and optional multiply) iterate one bit per clock. Result and OF/BF/PF/VF flags are registered and held until the consumer accepts them.

Parameters:
BITS, 8, operand/result width (>=4)
N, 4, opcode width
CRC_W, 4, CRC width; generator taken from i_argB[CRC_W-1:0], implicit x^CRC_W term (CRC_W < BITS)
LEN, $clog2(BITS), localparam: shift-amount and counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  operands/opcode valid
o_ready  out  1  unit can accept
i_oper  in  N  opcode
i_argA  in  BITS  operand A (signed)
i_argB  in  BITS  operand B (signed)
o_valid  out  1  result/flags valid
i_ready  in  1  consumer accepts result
o_result  out  BITS  result
o_OF, o_BF, o_PF, o_VF  out  1 each  flags

Behaviour:
- Clock/reset: single clock i_clk; reset i_rst_n asynchronous, active-low. On reset: state IDLE, o_valid=0, o_result='0, all flags 0, o_ready=1 after reset release.
- FSM IDLE/CALC/HOLD. o_ready = (state==IDLE). Accept = i_valid && o_ready; i_oper/i_argA/i_argB latched on accept. Input changes after accept have no effect. i_valid while not IDLE is ignored.
- IDLE -> HOLD on accept of a single-cycle op: o_valid=1 on the next edge (latency 1).
- IDLE -> CALC on accept of a serial op; CALC runs exactly BITS cycles, then -> HOLD (latency BITS+1).
- HOLD: o_valid=1; o_result and flags stable until i_ready=1; then -> IDLE. Max throughput is one op per 2 clocks.
- Opcodes:
  - 0000: A+B, wraps modulo 2^BITS; VF = signed overflow.
  - 0001: ~(A|B).
  - 0010: ~(A&B).
  - 0011: A<<B; if B>=BITS (unsigned), result 0.
  - 0100: A>>>B; if B>=BITS, sign fill.
  - 0101: Gray of A.
  - 0110: count of zero bits in A.
  - 0111: one-hot A -> binary index; non-one-hot A gives all ones.
  - 1000: serial CRC. Register init 0; A fed MSB first, one bit/cycle; fb = crc[MSB]^bit; crc = (crc<<1) ^ (fb ? poly : 0). Result zero-extended to BITS.
  - 1001: A-B; VF = signed overflow.
  - Any other opcode: result all ones.
- Flags are computed from the final result and registered with it:
  - OF = result all ones.
  - BF = exactly one bit set.
  - PF = odd popcount.
  - VF = 0 except where stated.
- Reset mid-CALC or mid-HOLD: partial/held result is discarded; outputs go to reset values immediately.

Optional Feature:
EXE_SEQ_MUL_EN
- Defined: opcode 1010 = unsigned shift-add multiply A*B, serial, BITS iterations in CALC, latency BITS+1. o_result = low BITS of product; VF=1 if the high BITS are non-zero.
- Undefined: 1010 is invalid (all ones, OF=1, latency 1); no multiplier logic is synthesised.

Decomposition:
- Package exe_pkg holds:
  - opcode localparams (OP_ADD … OP_SUB, OP_MUL);
  - state enum (IDLE, CALC, HOLD);
  - helper function flags(result) returning {OF,BF,PF}.
- Sub-module exe_serial_core: the bit-serial CRC/multiply datapath with a start/done interface; the top keeps FSM, handshake and single-cycle ops.

Test Plan:
1. Reset (BITS=8), then ADD A=8'd100, B=8'd50, i_ready=1 -> 1 cycle later o_valid=1, o_result=8'h96, VF=1, OF=0, BF=0, PF=0.
2. One-hot A=8'h10 -> o_result=8'h04, BF=1, PF=1; A=8'h11 -> 8'hFF, OF=1, PF=0.
3. CRC A=8'h80, B=8'h03, CRC_W=4 -> o_ready low 9 cycles; o_valid on cycle 9; o_result=8'h0E, PF=1; i_valid pulses during CALC are ignored.
4. Backpressure: complete ADD 1+1 with i_ready=0 for 3 cycles -> o_result=8'h02, flags and o_valid stable; o_ready=0 throughout; IDLE the cycle after i_ready=1.
5. Assert i_rst_n=0 at CRC iteration 4 -> o_valid=0, o_result=0 immediately; next op after release produces correct results.
6. Opcode 1010, A=8'd20, B=8'd13: with EXE_SEQ_MUL_EN -> 8'h04, VF=1, latency 9; without -> 8'hFF, OF=1, latency 1.
